piece_dropper: RTL

PIECE_DROPPER -- requirements
Module: piece_dropper

---
 rtl/tetris_pkg.sv | 56 +++++
 rtl/piece_fit.sv | 31 +++
 rtl/piece_dropper.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared constants, FSM state type and the shape offset table for the falling-piece logic.
package tetris_pkg;

  localparam int PF_X0       = 200;
  localparam int CELL        = 20;
  localparam int COLS        = 10;
  localparam int ROWS        = 20;
  localparam int GRAV_FRAMES = 30;
  localparam int FAST_FRAMES = 2;

  localparam logic [3:0] SPAWN_COL = 4'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPAWN = 3'd1,
    FALL  = 3'd2,
    LOCK  = 3'd3,
    OVER  = 3'd4
  } state_t;

  // Column offset of square idx for a shape: 0=I, 1=O, 2=T, 3=L.
  // Tables are packed {sq3, sq2, sq1, sq0}.
  function automatic logic [1:0] off_col(input logic [1:0] shape, input logic [1:0] idx);
    logic [7:0] tab;
    case (shape)
      2'd0:    tab = {2'd3, 2'd2, 2'd1, 2'd0};
      2'd1:    tab = {2'd1, 2'd0, 2'd1, 2'd0};
      2'd2:    tab = {2'd1, 2'd2, 2'd1, 2'd0};
      default: tab = {2'd2, 2'd1, 2'd0, 2'd0};
    endcase
    return tab[{idx, 1'b0} +: 2];
  endfunction

  // Row offset of square idx for a shape, packed {sq3, sq2, sq1, sq0}.
  function automatic logic off_row(input logic [1:0] shape, input logic [1:0] idx);
    logic [3:0] tab;
    case (shape)
      2'd0:    tab = 4'b0000;
      2'd1:    tab = 4'b1100;
      2'd2:    tab = 4'b1000;
      default: tab = 4'b1110;
    endcase
    return tab[idx];
  endfunction

  // Pixel x of a playfield column; col never exceeds 12, so 10 bits cannot overflow.
  function automatic logic [9:0] cell_x(input logic [4:0] col);
    return 10'(PF_X0) + 10'(CELL) * {5'd0, col};
  endfunction

  // Pixel y of a playfield row.
  function automatic logic [9:0] cell_y(input logic [4:0] row);
    return 10'(CELL) * {5'd0, row};
  endfunction

endpackage

// File: rtl/piece_fit.sv
// Combinational check: does a shape anchored at (col,row) lie fully inside the
// playfield without touching any locked cell. Sums are 5 bits wide and are
// range-checked before they are used to index the board.
module piece_fit
  import tetris_pkg::*;
(
  input  logic [4:0]                 col_i,
  input  logic [4:0]                 row_i,
  input  logic [1:0]                 shape_i,
  input  logic [ROWS-1:0][COLS-1:0]  occupied_i,
  output logic                       fits_o
);

  logic [4:0] cell_c [4];
  logic [4:0] cell_r [4];

  // Walk the four squares; any out-of-range or occupied cell rejects the placement.
  always_comb begin
    fits_o = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cell_c[i] = col_i + {3'b000, off_col(shape_i, 2'(i))};
      cell_r[i] = row_i + {4'b0000, off_row(shape_i, 2'(i))};
      if (cell_c[i] >= 5'(COLS) || cell_r[i] >= 5'(ROWS)) begin
        fits_o = 1'b0;
      end else if (occupied_i[cell_r[i]][cell_c[i][3:0]]) begin
        fits_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/piece_dropper.sv
// Falling-piece controller: spawns a piece, applies gravity on frame ticks,
// handles left/right moves against the locked-cell map and signals when the
// piece has landed so the gameboard can absorb it.
module piece_dropper
  import tetris_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       frame_tick,
  input  logic                       move_left,
  input  logic                       move_right,
  input  logic                       drop_fast,
  input  logic [1:0]                 shape_sel,
  input  logic [ROWS-1:0][COLS-1:0]  occupied,
  output logic [9:0]                 square1x,
  output logic [9:0]                 square2x,
  output logic [9:0]                 square3x,
  output logic [9:0]                 square4x,
  output logic [9:0]                 square1y,
  output logic [9:0]                 square2y,
  output logic [9:0]                 square3y,
  output logic [9:0]                 square4y,
  output logic                       at_bottom,
  output logic                       game_over,
  output state_t                     dbg_state
);

  state_t     state_q, state_d;
  logic [3:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic [1:0] shape_q, shape_d;
  logic [4:0] grav_q, grav_d;
  logic       lock_q, lock_d;
  logic       upd_q, upd_d;        // anchor moved last cycle; refresh square outputs
  logic       at_bottom_q, at_bottom_d;
  logic [9:0] sq_x_q [4];
  logic [9:0] sq_y_q [4];
  logic [9:0] sq_x_d [4];
  logic [9:0] sq_y_d [4];

  logic spawn_fits, left_fits, right_fits, below_fits;
  logic [4:0] grav_inc, grav_lim;
  logic       step_due;

  piece_fit u_fit_spawn (
    .col_i      ({1'b0, SPAWN_COL}),
    .row_i      (5'd0),
    .shape_i    (shape_sel),
    .occupied_i (occupied),
    .fits_o     (spawn_fits)
  );

  // Only consulted when col_q is non-zero, so the subtraction never wraps.
  piece_fit u_fit_left (
    .col_i      ({1'b0, col_q} - 5'd1),
    .row_i      (row_q),
    .shape_i    (shape_q),
    .occupied_i (occupied),
    .fits_o     (left_fits)
  );

  piece_fit u_fit_right (
    .col_i      ({1'b0, col_q} + 5'd1),
    .row_i      (row_q),
    .shape_i    (shape_q),
    .occupied_i (occupied),
    .fits_o     (right_fits)
  );

  piece_fit u_fit_below (
    .col_i      ({1'b0, col_q}),
    .row_i      (row_q + 5'd1),
    .shape_i    (shape_q),
    .occupied_i (occupied),
    .fits_o     (below_fits)
  );

  assign grav_inc = grav_q + 5'd1;
  assign grav_lim = drop_fast ? 5'(FAST_FRAMES) : 5'(GRAV_FRAMES);

  // Next-state logic: gravity has priority over moves; simultaneous left+right is ignored.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    shape_d     = shape_q;
    grav_d      = grav_q;
    lock_d      = lock_q;
    upd_d       = 1'b0;
    at_bottom_d = 1'b0;
    step_due    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SPAWN;
      end
      SPAWN: begin
        col_d   = SPAWN_COL;
        row_d   = 5'd0;
        shape_d = shape_sel;
        grav_d  = 5'd0;
        if (spawn_fits) begin
          state_d = FALL;
          upd_d   = 1'b1;
        end else begin
          // Outputs keep the previous piece: no refresh is scheduled.
          state_d = OVER;
        end
      end
      FALL: begin
        if (frame_tick) begin
          if (grav_inc >= grav_lim) step_due = 1'b1;
          else                      grav_d   = grav_inc;
        end
        if (step_due) begin
          grav_d = 5'd0;
          if (below_fits) begin
            row_d = row_q + 5'd1;
            upd_d = 1'b1;
          end else begin
            at_bottom_d = 1'b1;
            lock_d      = 1'b0;
            state_d     = LOCK;
          end
        end else if (move_left && !move_right && col_q != 4'd0 && left_fits) begin
          col_d = col_q - 4'd1;
          upd_d = 1'b1;
        end else if (move_right && !move_left && right_fits) begin
          col_d = col_q + 4'd1;
          upd_d = 1'b1;
        end
      end
      LOCK: begin
        if (lock_q) state_d = SPAWN;
        else        lock_d  = 1'b1;
      end
      OVER: begin
        state_d = OVER;
      end
      default: state_d = IDLE;
    endcase
  end

  // Square positions follow the anchor one cycle after it changes.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sq_x_d[i] = sq_x_q[i];
      sq_y_d[i] = sq_y_q[i];
      if (upd_q) begin
        sq_x_d[i] = cell_x({1'b0, col_q} + {3'b000, off_col(shape_q, 2'(i))});
        sq_y_d[i] = cell_y(row_q + {4'b0000, off_row(shape_q, 2'(i))});
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      shape_q     <= '0;
      grav_q      <= '0;
      lock_q      <= 1'b0;
      upd_q       <= 1'b0;
      at_bottom_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sq_x_q[i] <= '0;
        sq_y_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      shape_q     <= shape_d;
      grav_q      <= grav_d;
      lock_q      <= lock_d;
      upd_q       <= upd_d;
      at_bottom_q <= at_bottom_d;
      for (int i = 0; i < 4; i++) begin
        sq_x_q[i] <= sq_x_d[i];
        sq_y_q[i] <= sq_y_d[i];
      end
    end
  end

  assign square1x  = sq_x_q[0];
  assign square2x  = sq_x_q[1];
  assign square3x  = sq_x_q[2];
  assign square4x  = sq_x_q[3];
  assign square1y  = sq_y_q[0];
  assign square2y  = sq_y_q[1];
  assign square3y  = sq_y_q[2];
  assign square4y  = sq_y_q[3];
  assign at_bottom = at_bottom_q;
  assign game_over = (state_q == OVER);
  assign dbg_state = state_q;

endmodule
